// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between two requesters.
//   Port 0 is the CPU memory port; port 1 is the loader/debug port.
//   Round-robin arbitration with a burst cap; read data returns to the issuing port.
// Ports:
//   CLK, rst_n              clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN   request, write enable, byte address, write data (N = 0, 1)
//   gntN                    access performed this cycle
//   rvalidN/rdataN          read data return, one cycle after a read grant
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata   memory side
//   owner                   0 = idle, 1 = port 0 owns, 2 = port 1 owns
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e      r_state, w_state_nxt;
    logic        r_last, w_last_nxt;      // last port granted (1 = port 1)
    logic [3:0]  r_cnt, w_cnt_nxt;        // consecutive grants to the current owner
    logic        r_rvalid0, r_rvalid1;

    logic        w_gnt0, w_gnt1;
    logic [4:0]  w_cnt_inc;
    logic        w_cap;
    logic [3:0]  w_cnt_sat;

    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
    assign w_cap     = (w_cnt_inc == 5'(MAX_BURST));
    // Without competition the count just sticks at 15.
    assign w_cnt_sat = (r_cnt == 4'hF) ? r_cnt : w_cnt_inc[3:0];

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_last    <= 1'b1;
            r_cnt     <= 4'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rvalid0 <= w_gnt0 & ~we0;
            r_rvalid1 <= w_gnt1 & ~we1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = 4'd0;
                if (req0 && req1) begin
                    w_state_nxt = r_last ? StOwn0 : StOwn1;
                end else if (req0) begin
                    w_state_nxt = StOwn0;
                end else if (req1) begin
                    w_state_nxt = StOwn1;
                end
            end
            StOwn0: begin
                if (w_gnt0) begin
                    w_last_nxt = 1'b0;
                    w_cnt_nxt  = w_cnt_sat;
                end
                if (req1 && ((w_cap && w_gnt0) || !req0)) begin
                    w_state_nxt = StOwn1;
                    w_cnt_nxt   = 4'd0;
                end else if (!req0 && !req1) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = 4'd0;
                end
            end
            StOwn1: begin
                if (w_gnt1) begin
                    w_last_nxt = 1'b1;
                    w_cnt_nxt  = w_cnt_sat;
                end
                if (req0 && ((w_cap && w_gnt1) || !req1)) begin
                    w_state_nxt = StOwn0;
                    w_cnt_nxt   = 4'd0;
                end else if (!req0 && !req1) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output logic: only the owner can be granted, and only while it requests.
    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        owner     = 2'd0;
        unique case (r_state)
            StOwn0: begin
                owner  = 2'd1;
                w_gnt0 = req0;
                if (req0) begin
                    mem_re    = ~we0;
                    mem_we    = we0;
                    mem_addr  = addr0;
                    mem_wdata = wdata0;
                end
            end
            StOwn1: begin
                owner  = 2'd2;
                w_gnt1 = req1;
                if (req1) begin
                    mem_re    = ~we1;
                    mem_we    = we1;
                    mem_addr  = addr1;
                    mem_wdata = wdata1;
                end
            end
            default: begin
                owner = 2'd0;
            end
        endcase
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rvalid0 ? mem_rdata : 32'h0;
    assign rdata1  = r_rvalid1 ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural memory,
// a reference memory image and per-port queues of expected read data.
module tb_mem_arbiter;

    localparam int unsigned MaxBurst = 4;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mem_arr [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_BURST(MaxBurst)) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .owner    (owner)
    );

    // Behavioural single-ported memory, word indexed by addr[9:2].
    always @(posedge CLK) begin
        if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_arr[mem_addr[9:2]];
    end

    // Scoreboard pop and grant exclusivity on every cycle out of reset.
    always @(negedge CLK) begin
        logic [31:0] exp;
        if (rst_n) begin
            total++;
            if (gnt0 && gnt1) begin
                bad++;
                $display("FAIL gnt_excl got gnt0=%b gnt1=%b required at most one", gnt0, gnt1);
            end
            if (rvalid0) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid0_unexp got rdata0=%h required no response", rdata0);
                end else begin
                    exp = q0.pop_front();
                    if (rdata0 !== exp) begin
                        bad++;
                        $display("FAIL rdata0 got %h required %h", rdata0, exp);
                    end
                end
            end
            if (rvalid1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid1_unexp got rdata1=%h required no response", rdata1);
                end else begin
                    exp = q1.pop_front();
                    if (rdata1 !== exp) begin
                        bad++;
                        $display("FAIL rdata1 got %h required %h", rdata1, exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    // One access on port p; held until granted, released after the grant edge.
    task automatic access(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
        int  n;
        logic g;
        @(posedge CLK);
        #1;
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        if (w) ref_mem[a[9:2]] = d;
        else if (p == 0) q0.push_back(ref_mem[a[9:2]]);
        else q1.push_back(ref_mem[a[9:2]]);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            g = (p == 0) ? gnt0 : gnt1;
        end while (!g && n < 20);
        total++;
        if (!g) begin
            bad++;
            $display("FAIL access_gnt port=%0d got gnt=0 required 1 within 20 cycles", p);
        end
        @(posedge CLK);
        #1;
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0;
        repeat (2) @(negedge CLK);
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_re, mem_we} !== 6'b0) begin
            bad++;
            $display("FAIL rst_ctrl got %b required 000000",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_re, mem_we});
        end
        total++;
        if ({rdata0, rdata1} !== 64'h0) begin
            bad++;
            $display("FAIL rst_rdata got %h %h required 0 0", rdata0, rdata1);
        end
        total++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL rst_membus got %h %h required 0 0", mem_addr, mem_wdata);
        end
        total++;
        if (owner !== 2'd0) begin
            bad++;
            $display("FAIL rst_owner got %0d required 0", owner);
        end
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        q0.push_back(ref_mem[8'h40]);
        @(negedge CLK);
        total++;
        if (gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_lat_idle got gnt0=%b required 0", gnt0);
        end
        @(negedge CLK);
        total++;
        if (gnt0 !== 1'b1 || owner !== 2'd1) begin
            bad++;
            $display("FAIL rst_first_gnt got gnt0=%b owner=%0d required 1 1", gnt0, owner);
        end
        total++;
        if (mem_re !== 1'b1 || mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL rst_first_bus got re=%b addr=%h required 1 100", mem_re, mem_addr);
        end
        @(posedge CLK);
        #1;
        req0 = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_single_read;
        access(1, 1'b1, 32'h40, 32'hDEADBEEF);
        access(0, 1'b0, 32'h40, 32'h0);
        @(negedge CLK);
        total++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL single_read got rv0=%b rd0=%h rv1=%b required 1 deadbeef 0",
                     rvalid0, rdata0, rvalid1);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_tie_burst;
        int exp_p;
        access(0, 1'b1, 32'h200, 32'hA0A00001);
        access(1, 1'b1, 32'h300, 32'hB1B10002);
        @(posedge CLK);
        #1;
        rst_n = 1'b0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h200;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h300;
        @(negedge CLK);
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL tie_idle got gnt0=%b gnt1=%b required 0 0", gnt0, gnt1);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            exp_p = (k / MaxBurst) % 2;
            total++;
            if (gnt0 !== (exp_p == 0) || gnt1 !== (exp_p == 1)) begin
                bad++;
                $display("FAIL burst_pattern cycle=%0d got gnt0=%b gnt1=%b required port %0d",
                         k, gnt0, gnt1, exp_p);
            end
            if (exp_p == 0) q0.push_back(ref_mem[8'h80]);
            else q1.push_back(ref_mem[8'hC0]);
        end
        @(posedge CLK);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_owner_drop;
        @(posedge CLK);
        #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h200;
        @(posedge CLK);
        #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h12345678;
        ref_mem[8'h20] = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            total++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                bad++;
                $display("FAIL drop_own0 grant=%0d got gnt0=%b gnt1=%b required 1 0",
                         k, gnt0, gnt1);
            end
            q0.push_back(ref_mem[8'h80]);
        end
        @(posedge CLK);
        #1;
        req0 = 1'b0;
        @(negedge CLK);
        total++;
        if ({gnt0, gnt1, mem_re, mem_we} !== 4'b0) begin
            bad++;
            $display("FAIL drop_switch got gnt0/gnt1/re/we=%b required 0000",
                     {gnt0, gnt1, mem_re, mem_we});
        end
        @(negedge CLK);
        total++;
        if (gnt1 !== 1'b1 || owner !== 2'd2) begin
            bad++;
            $display("FAIL drop_gnt1 got gnt1=%b owner=%0d required 1 2", gnt1, owner);
        end
        total++;
        if (mem_addr !== 32'h80 || mem_we !== 1'b1 || mem_re !== 1'b0
            || mem_wdata !== 32'h12345678) begin
            bad++;
            $display("FAIL drop_bus got addr=%h we=%b re=%b wd=%h required 80 1 0 12345678",
                     mem_addr, mem_we, mem_re, mem_wdata);
        end
        @(posedge CLK);
        #1;
        req1 = 1'b0;
        access(0, 1'b0, 32'h80, 32'h0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        int n;
        @(posedge CLK);
        #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h300;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!gnt1 && n < 20);
        total++;
        if (!gnt1) begin
            bad++;
            $display("FAIL mid_gnt1 got gnt1=0 required 1 within 20 cycles");
        end
        @(posedge CLK);
        #2;
        rst_n = 1'b0;
        req1 = 1'b0;
        #1;
        total++;
        if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL mid_rvalid1 got rv1=%b rd1=%h required 0 0", rvalid1, rdata1);
        end
        total++;
        if (owner !== 2'd0 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_owner got owner=%0d gnt1=%b required 0 0", owner, gnt1);
        end
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if (owner !== 2'd0) begin
            bad++;
            $display("FAIL mid_idle got owner=%0d required 0", owner);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_rdata = 32'h0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        rst_n = 1'b0;

        test_reset();
        test_single_read();
        test_tie_burst();
        test_owner_drop();
        test_reset_mid();

        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL pending_reads got q0=%0d q1=%0d required 0 0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-ported unified Memory between the multicycle CPU's memory port (port 0: fetch, load and store) and a loader/debug port (port 1: program load, memory inspection). It sits between both requesters and the Memory instance. Each cycle it grants at most one access. Arbitration is round-robin with a burst cap. Read data is routed back to the port that issued the read.

## Interface
- `MAX_BURST`, default 4: maximum consecutive granted accesses by one port while the other port is requesting; legal range 1..15.
- `CLK` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `req0`, `req1` in 1: access request. Must be held, together with the matching `we`, `addr` and `wdata`, until `gnt` is seen high.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in 32: byte address, passed to memory unchanged.
- `wdata0`, `wdata1` in 32: write data.
- `gnt0`, `gnt1` out 1: access performed this cycle.
- `rvalid0`, `rvalid1` out 1: read data valid on `rdata` this cycle.
- `rdata0`, `rdata1` out 32: read data; equals `mem_rdata` while the matching `rvalid` is high, 0 otherwise.
- `mem_re`, `mem_we` out 1: Memory read/write enables.
- `mem_addr`, `mem_wdata` out 32: Memory address and write data.
- `mem_rdata` in 32: Memory read data, valid the cycle after `mem_re`.
- `owner` out 2: 0 = idle, 1 = port 0 owns, 2 = port 1 owns.

## Operation
- **FSM states:** IDLE, OWN0, OWN1. Registered state holds `last`, the last port granted, and `cnt`, a 4-bit count of consecutive grants.
- **IDLE:**
  - No grants; `mem_re`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
  - `req0` and `req1` together: go to OWN of the port other than `last`.
  - Only one request: go to OWN of that port.
  - On entry, `cnt` = 0.
- **OWNx:**
  - `gntx` = `reqx` combinationally. When `gntx` is 1, `mem_*` is driven from port x: `mem_re` = !`wex`, `mem_we` = `wex`. Otherwise `mem_*` is all 0.
  - On a grant: `last` <= x, `cnt` <= `cnt` + 1.
  - Next state, evaluated in priority order:
    1. Other port requesting and (`cnt` + 1 == `MAX_BURST` with `gntx`, or !`reqx`): go to OWN(other), `cnt` <= 0.
    2. !`reqx` and other port not requesting: go to IDLE.
    3. Otherwise stay in OWNx.
  - `cnt` saturates at 15 when there is no competition.
- **Granting rule:** the non-owner port is never granted. At most one of `gnt0`/`gnt1` is high in any cycle.
- **Read return:** `rvalidx` <= `gntx` & !`wex` (registered). `rdatax` = `rvalidx` ? `mem_rdata` : 0.
- **Writes** commit at the edge ending the grant cycle and produce no response.
- **Reset values:** state IDLE, `last` = 1 (port 0 wins the first tie), `cnt` = 0, `rvalid0`/`rvalid1` = 0. All outputs are 0.

## Timing
- **Request from IDLE:** grant arrives on the cycle after `req` is first sampled, giving 1 cycle of latency.
- **Read data:** `rvalid` is high exactly 1 cycle after the grant cycle.
- **Owner streaming:** with `req` held high and no competition, the owner is granted every cycle.
- **Ownership switch with competition:** the first grant to the new port comes on the cycle after the last owner grant. There is no dead cycle.
- **Owner drops `req`:** one cycle with no grant (the switch cycle), then the other port is granted the following cycle.
- **Simultaneous read return and new grant:** allowed, because `rvalid` and `gnt` are independent.
- **Reset mid-operation:**
  - State returns to IDLE immediately.
  - Any pending `rvalid` is dropped.
  - The requester must reissue its request.
  - A write granted in the same cycle that reset asserts is not guaranteed to complete.

## Test plan
- **Reset:** `rst_n` = 0 with `req0` = 1 -> all outputs 0 and `owner` = 0. Release reset -> `gnt0` one cycle later.
- **Single read:** write `0xDEADBEEF` to 0x40 via port 1, then read 0x40 via port 0 -> `gnt0` pulse, then `rvalid0` = 1 with `rdata0` = `0xDEADBEEF` next cycle; `rvalid1` stays 0.
- **Tie from IDLE:** `req0` and `req1` asserted in the same cycle after reset -> port 0 granted first, then port 1 after `MAX_BURST` grants.
- **Burst cap:** `MAX_BURST` = 4, both ports requesting continuously -> grant pattern 0,0,0,0,1,1,1,1,0..., and never two grants in one cycle.
- **Owner drop:** port 0 drops `req0` after 2 grants while `req1` is held -> one idle cycle, then `gnt1`. Check that `mem_addr` = `addr1` and `mem_we` = `we1` in that cycle.
- **Reset mid-burst:** assert `rst_n` = 0 during the cycle after a port 1 read grant -> no `rvalid1`, state IDLE, `owner` = 0.
